// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU between NUM_REQ requesters.
// The ALU result is captured in a one-entry output register with a valid/ready handshake.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*64-1:0] req_opr_a_i,
  input  logic [NUM_REQ*64-1:0] req_opr_b_i,
  input  logic [NUM_REQ*4-1:0]  req_func_i,
  output logic [63:0]           alu_opr_a_o,
  output logic [63:0]           alu_opr_b_o,
  output logic [3:0]            alu_func_o,
  input  logic [63:0]           alu_res_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_res_o,
  output logic [ID_W-1:0]       rsp_id_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_found;
  logic             can_accept;
  logic             accept;

  // Scan from the requester after the last winner, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A full register that is draining this cycle may take a new result
  assign can_accept = !flush_i && (!rsp_valid_o || rsp_ready_i);
  assign accept     = can_accept && gnt_found;

  always_comb begin
    req_ready_o = '0;
    alu_opr_a_o = '0;
    alu_opr_b_o = '0;
    alu_func_o  = '0;
    if (accept) begin
      req_ready_o[gnt_idx] = 1'b1;
      alu_opr_a_o = req_opr_a_i[int'(gnt_idx)*64 +: 64];
      alu_opr_b_o = req_opr_b_i[int'(gnt_idx)*64 +: 64];
      alu_func_o  = req_func_i[int'(gnt_idx)*4 +: 4];
    end
  end

  // Result and id hold after a drain; only valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_res_o   <= '0;
      rsp_id_o    <= '0;
      last_gnt    <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_res_o   <= alu_res_i;
      rsp_id_o    <= ID_W'(gnt_idx);
      last_gnt    <= gnt_idx;
    end else if (flush_i || rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter with a stub ALU and a queue-based
// reference model of grants and responses.
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqReady;
  logic [N*64-1:0] oprA;
  logic [N*64-1:0] oprB;
  logic [N*4-1:0]  func;
  logic [63:0]     aluA;
  logic [63:0]     aluB;
  logic [3:0]      aluFunc;
  logic [63:0]     aluRes;
  logic            rspValid;
  logic            rspReady;
  logic [63:0]     rspRes;
  logic [IW-1:0]   rspId;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [63:0] res;
  } rsp_t;

  rsp_t sb[$];
  int   modelLast;
  int   lastWin;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .req_valid_i(reqValid),
    .req_ready_o(reqReady),
    .req_opr_a_i(oprA),
    .req_opr_b_i(oprB),
    .req_func_i(func),
    .alu_opr_a_o(aluA),
    .alu_opr_b_o(aluB),
    .alu_func_o(aluFunc),
    .alu_res_i(aluRes),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .rsp_res_o(rspRes),
    .rsp_id_o(rspId)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] aluFn(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 64'd0;
    endcase
  endfunction

  // Stub of the shared ALU
  always_comb aluRes = aluFn(aluFunc, aluA, aluB);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setReq(input int n, input logic v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] f);
    reqValid[n]     = v;
    oprA[n*64 +: 64] = a;
    oprB[n*64 +: 64] = b;
    func[n*4 +: 4]   = f;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    modelLast = N - 1;
    lastWin   = -1;
  endtask

  // One clock: check outputs against the model at negedge, then advance the model
  task automatic applyStimulus();
    logic          full;
    logic          canAcc;
    int            win;
    logic [N-1:0]  expReady;
    logic [63:0]   expA, expB;
    logic [3:0]    expF;
    @(negedge clk);
    full   = (sb.size() > 0);
    canAcc = !flush && (!full || rspReady);
    win    = -1;
    if (canAcc)
      for (int k = 1; k <= N; k++)
        if (win < 0 && reqValid[(modelLast + k) % N]) win = (modelLast + k) % N;
    expReady = '0;
    expA = '0;
    expB = '0;
    expF = '0;
    if (win >= 0) begin
      expReady[win] = 1'b1;
      expA = oprA[win*64 +: 64];
      expB = oprB[win*64 +: 64];
      expF = func[win*4 +: 4];
    end
    checkOutput("req_ready", 64'(reqReady), 64'(expReady));
    checkOutput("alu_a", aluA, expA);
    checkOutput("alu_b", aluB, expB);
    checkOutput("alu_func", 64'(aluFunc), 64'(expF));
    checkOutput("rsp_valid", 64'(rspValid), 64'(full));
    if (full) begin
      checkOutput("rsp_res", rspRes, sb[0].res);
      checkOutput("rsp_id", 64'(rspId), 64'(sb[0].id));
    end
    if (full && (rspReady || flush)) void'(sb.pop_front());
    if (win >= 0) begin
      sb.push_back('{win, aluFn(expF, expA, expB)});
      modelLast = win;
    end
    lastWin = win;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    reqValid = '0;
    oprA     = '0;
    oprB     = '0;
    func     = '0;
    rspReady = 1'b1;
    doReset();
    checkOutput("reset_valid", 64'(rspValid), 64'd0);
    checkOutput("reset_res", rspRes, 64'd0);
    checkOutput("reset_id", 64'(rspId), 64'd0);

    // Single requester 0: 5 + 7
    setReq(0, 1'b1, 64'd5, 64'd7, OP_ADD);
    applyStimulus();
    checkOutput("tp1_valid", 64'(rspValid), 64'd1);
    checkOutput("tp1_res", rspRes, 64'd12);
    checkOutput("tp1_id", 64'(rspId), 64'd0);

    // Two requesters continuously valid: alternation
    setReq(0, 1'b1, 64'd10, 64'd3, OP_SUB);
    setReq(1, 1'b1, 64'hF0, 64'h0F, OP_XOR);
    repeat (6) applyStimulus();

    // Stall for three cycles, then release
    rspReady = 1'b0;
    repeat (3) applyStimulus();
    rspReady = 1'b1;
    repeat (2) applyStimulus();

    // Flush while holding a result with req1 valid
    setReq(0, 1'b0, 64'd0, 64'd0, OP_ADD);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    repeat (2) applyStimulus();

    // Reset while a result is held and req0 valid
    setReq(0, 1'b1, 64'd1, 64'd2, OP_OR);
    applyStimulus();
    doReset();
    checkOutput("midrst_valid", 64'(rspValid), 64'd0);
    checkOutput("midrst_res", rspRes, 64'd0);
    checkOutput("midrst_id", 64'(rspId), 64'd0);
    applyStimulus();
    checkOutput("midrst_first_id", 64'(rspId), 64'd0);

    // Only requesters 2 and 3 valid
    setReq(0, 1'b0, 64'd0, 64'd0, OP_ADD);
    setReq(1, 1'b0, 64'd0, 64'd0, OP_ADD);
    setReq(2, 1'b1, 64'hFF00, 64'h0FF0, OP_AND);
    setReq(3, 1'b1, 64'h1234, 64'h0001, OP_ADD);
    repeat (4) applyStimulus();

    // Random traffic; an unaccepted valid request keeps its operands
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int n = 0; n < N; n++)
        if (!(reqValid[n] && lastWin != n) || lastWin < 0 && !reqValid[n])
          setReq(n, ($urandom_range(0, 99) < 60), {$urandom, $urandom}, {$urandom, $urandom},
                 4'($urandom_range(0, 5)));
      rspReady = ($urandom_range(0, 99) < 70);
      flush    = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 64-bit integer ALU between up to NUM_REQ requesters, e.g. the main issue slot, branch-target compute and the address-generation helper.
- Grants are round-robin with a valid/ready handshake per requester.
- The granted operands and function code drive the ALU combinationally; the result is captured in a one-entry output register with a backpressure handshake, so a granted operation returns one cycle after acceptance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, 3, width of the requester index on rsp_id_o; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  discards the held result and blocks acceptance this cycle.
- req_valid_i  in  NUM_REQ  bit n set: requester n presents an operation.
- req_ready_o  out  NUM_REQ  one-hot or zero; bit n set: requester n's operation is accepted this cycle.
- req_opr_a_i  in  NUM_REQ*64  operand A; requester n occupies slice [64n+63:64n].
- req_opr_b_i  in  NUM_REQ*64  operand B, same packing as operand A.
- req_func_i  in  NUM_REQ*4  ALU function code (cpu_consts OP_* encoding); slice [4n+3:4n].
- alu_opr_a_o  out  64  operand A to the shared ALU.
- alu_opr_b_o  out  64  operand B to the shared ALU.
- alu_func_o  out  4  function code to the shared ALU.
- alu_res_i  in  64  combinational result from the shared ALU.
- rsp_valid_o  out  1  the output register holds a result.
- rsp_ready_i  in  1  the consumer takes the result this cycle.
- rsp_res_o  out  64  registered ALU result.
- rsp_id_o  out  ID_W  index of the requester that owns rsp_res_o.

Behaviour:
- Reset values:
  - rsp_valid_o=0, rsp_res_o=0, rsp_id_o=0.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 has top priority after reset.
  - A reset asserted mid-operation drops the held result with no response.
- can_accept = !flush_i && (!rsp_valid_o || rsp_ready_i). Pass-through is allowed when full and draining.
- Grant selection:
  - Scan requesters starting at (last_gnt+1) mod NUM_REQ, wrapping around.
  - The first n with req_valid_i[n]=1 wins; gnt is one-hot or zero.
- req_ready_o = gnt when can_accept, else 0.
  - ready depends on valid; requesters must not make valid depend on ready.
- ALU drive:
  - When can_accept and a grant exists, alu_opr_a_o/alu_opr_b_o/alu_func_o are the winner's slices.
  - Otherwise all three are 0.
- Acceptance (any req_ready_o bit set):
  - Next cycle: rsp_valid_o=1, rsp_res_o=alu_res_i, rsp_id_o=winner index.
  - last_gnt updates to the winner. Latency is exactly 1 cycle.
- Drain without a new accept (rsp_valid_o && rsp_ready_i and no grant): rsp_valid_o goes to 0. rsp_res_o and rsp_id_o hold their values.
- Stall (rsp_valid_o && !rsp_ready_i):
  - req_ready_o=0 and the output register holds.
  - last_gnt is unchanged.
  - Requesters keep valid and operands stable (AXI-style: once valid, hold until ready).
- Flush:
  - Next cycle rsp_valid_o=0.
  - No acceptance and no pointer update in the flush cycle.
  - A result presented together with flush_i and rsp_ready_i is treated as consumed, not duplicated.
- Fairness: with all NUM_REQ requesters continuously valid and rsp_ready_i=1, grants rotate 0,1,...,NUM_REQ-1,0 and each requester receives one grant every NUM_REQ cycles.
- Single requester: with only requester n valid, it is granted every cycle, whatever last_gnt holds.
- Throughput: one operation per cycle while rsp_ready_i stays 1.
- No operation is lost or duplicated: every req_valid&&req_ready pair produces exactly one rsp_valid&&rsp_ready pair, or is dropped by flush/reset.
- The function code is passed through unmodified; undefined codes produce whatever the ALU returns (0 by the ALU default).

Test Plan:
- Reset, then only req0 valid with A=5, B=7, func=OP_ADD and rsp_ready=1 -> req_ready_o=01; next cycle rsp_valid=1, rsp_res=12, rsp_id=0.
- Both valid continuously with rsp_ready=1 (req0 OP_SUB 10-3, req1 OP_XOR F0^0F) -> grants alternate 0,1,0,1; responses alternate 7 (id 0) and 0xFF (id 1), with no gaps.
- Output full and rsp_ready=0 for 3 cycles with both requesters valid -> req_ready_o=00 for those 3 cycles, rsp_res stable, last_gnt unchanged; when rsp_ready=1 the next grant goes to the next requester in round-robin order.
- flush_i pulsed while rsp_valid=1 and req1 valid -> next cycle rsp_valid=0, req_ready_o=00 during the flush cycle, and req1 is accepted the following cycle.
- Reset asserted while a result is held and req0 valid -> next cycle rsp_valid=0, rsp_res=0, rsp_id=0, and the first grant after reset goes to req0.
- NUM_REQ=4 with only req2 and req3 valid and last_gnt=3 -> grant sequence 2,3,2,3; alu_func_o matches the granted requester's code each cycle.
